// File: rtl/definitions.sv
// Shared miner-core definitions: ALU instruction encoding and the
// message-schedule sequencer state type.
package definitions;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_s;

  // Register fields stay 0; operands travel on the separate rd/rs buses.
  localparam instruction_s kADDU = instruction_s'(32'h0000_0033);
  localparam instruction_s kLA   = instruction_s'(32'h0000_100B);
  localparam instruction_s kLB   = instruction_s'(32'h0000_200B);

  localparam int kMsgWindow = 16;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LOAD = 4'd1,
    S_P1   = 4'd2,
    S_P2   = 4'd3,
    S_P3   = 4'd4,
    S_P4   = 4'd5,
    S_P5   = 4'd6,
    S_EMIT = 4'd7,
    S_DONE = 4'd8
  } msg_sched_state_e;

endpackage

// File: rtl/alu.sv
// Combinational miner-core ALU responder: kLA = sigma0(rs), kLB = sigma1(rs),
// kADDU = rd + rs mod 2^32; any other operation returns 0.
module alu
  import definitions::*;
(
  input  instruction_s op_i,
  input  logic [31:0]  rd_i,
  input  logic [31:0]  rs_i,
  output logic [31:0]  result_o
);

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  always_comb begin
    result_o = '0;
    if (op_i == kADDU) begin
      result_o = rd_i + rs_i;
    end else if (op_i == kLA) begin
      result_o = sigma0(rs_i);
    end else if (op_i == kLB) begin
      result_o = sigma1(rs_i);
    end
  end

endmodule

// File: rtl/msg_window.sv
// 16x32 circular message window: one write port and four combinational
// read ports at t-2, t-7, t-15 and t-16 (mod 16).
module msg_window
  import definitions::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  t_i,
  output logic [31:0] w_tm2_o,
  output logic [31:0] w_tm7_o,
  output logic [31:0] w_tm15_o,
  output logic [31:0] w_tm16_o
);

  logic [31:0] mem_q [kMsgWindow];
  logic [3:0]  addr_tm2, addr_tm7, addr_tm15;

  assign addr_tm2  = t_i - 4'd2;
  assign addr_tm7  = t_i - 4'd7;
  assign addr_tm15 = t_i - 4'd15;

  assign w_tm2_o  = mem_q[addr_tm2];
  assign w_tm7_o  = mem_q[addr_tm7];
  assign w_tm15_o = mem_q[addr_tm15];
  // t-16 lands on the slot being rewritten in P5; the read returns the old word.
  assign w_tm16_o = mem_q[t_i];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < kMsgWindow; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/msg_sched_seq.sv
// SHA-256 message-schedule sequencer: loads W0..W15, drives the ALU to expand
// W16..W(ROUNDS-1). MSGSCHED_PASSTHRU_EN also streams W0..W15 during LOAD.
module msg_sched_seq
  import definitions::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [31:0]  in_data_i,
  output instruction_s alu_op_o,
  output logic [31:0]  alu_rd_o,
  output logic [31:0]  alu_rs_o,
  input  logic [31:0]  alu_result_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [31:0]  out_data_o,
  output logic [5:0]   out_index_o,
  output logic         busy_o,
  output logic         done_o
);
  // state | meaning: IDLE wait start | LOAD fill window | P1..P5 ALU ops for W[t]
  //                  EMIT hold W[t] on output | DONE one-cycle completion pulse

  localparam logic [5:0] LastT = 6'(ROUNDS - 1);

  msg_sched_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] tmp_q, tmp_d;
  logic [31:0] word_q, word_d;
  logic        win_we, load_ready;
  logic [3:0]  win_waddr;
  logic [31:0] win_wdata;
  logic [31:0] w_tm2, w_tm7, w_tm15, w_tm16;

`ifdef MSGSCHED_PASSTHRU_EN
  assign load_ready = out_ready_i;
`else
  assign load_ready = 1'b1;
`endif

  msg_window u_window (
    .clk      (clk),
    .reset    (reset),
    .we_i     (win_we),
    .waddr_i  (win_waddr),
    .wdata_i  (win_wdata),
    .t_i      (t_q[3:0]),
    .w_tm2_o  (w_tm2),
    .w_tm7_o  (w_tm7),
    .w_tm15_o (w_tm15),
    .w_tm16_o (w_tm16)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      t_q     <= '0;
      acc_q   <= '0;
      tmp_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
      tmp_q   <= tmp_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    t_d         = t_q;
    acc_d       = acc_q;
    tmp_d       = tmp_q;
    word_d      = word_q;
    win_we      = 1'b0;
    win_waddr   = t_q[3:0];
    win_wdata   = alu_result_i;
    alu_op_o    = '0;
    alu_rd_o    = '0;
    alu_rs_o    = '0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_index_o = '0;
    busy_o      = (state_q != S_IDLE);
    done_o      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        in_ready_o = load_ready;
`ifdef MSGSCHED_PASSTHRU_EN
        out_valid_o = in_valid_i;
        out_data_o  = in_data_i;
        out_index_o = {2'b00, cnt_q};
`endif
        if (in_valid_i && load_ready) begin
          win_we    = 1'b1;
          win_waddr = cnt_q;
          win_wdata = in_data_i;
          cnt_d     = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = S_P1;
            t_d     = 6'd16;
          end
        end
      end
      S_P1: begin
        alu_op_o = kLB;
        alu_rs_o = w_tm2;
        acc_d    = alu_result_i;
        state_d  = S_P2;
      end
      S_P2: begin
        alu_op_o = kADDU;
        alu_rd_o = acc_q;
        alu_rs_o = w_tm7;
        acc_d    = alu_result_i;
        state_d  = S_P3;
      end
      S_P3: begin
        alu_op_o = kLA;
        alu_rs_o = w_tm15;
        tmp_d    = alu_result_i;
        state_d  = S_P4;
      end
      S_P4: begin
        alu_op_o = kADDU;
        alu_rd_o = acc_q;
        alu_rs_o = tmp_q;
        acc_d    = alu_result_i;
        state_d  = S_P5;
      end
      S_P5: begin
        alu_op_o = kADDU;
        alu_rd_o = acc_q;
        alu_rs_o = w_tm16;
        win_we   = 1'b1;
        word_d   = alu_result_i;
        state_d  = S_EMIT;
      end
      S_EMIT: begin
        out_valid_o = 1'b1;
        out_data_o  = word_q;
        out_index_o = t_q;
        if (out_ready_i) begin
          if (t_q == LastT) begin
            state_d = S_DONE;
          end else begin
            t_d     = t_q + 6'd1;
            state_d = S_P1;
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/msg_sched_seq.md
# msg_sched_seq

SHA-256 message-schedule sequencer for the miner core. It is the initiator side of the ALU operation interface: it issues `kLB`, `kLA` and `kADDU` operations to an `alu` instance and consumes the returned results. It accepts one 16-word block, expands it to W16..W(ROUNDS-1), and streams each expanded word out over a valid/ready port. It sits between the block loader and the compression-round logic.

## Interface
- `ROUNDS`, default 64: total schedule length. Legal range 17..64. Words W16..W(ROUNDS-1) are produced.
- `clk` input, 1 bit: the single clock; all state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `start_i` input, 1 bit: one-cycle pulse, honoured only in IDLE.
- `in_valid_i` input, 1 bit / `in_ready_o` output, 1 bit / `in_data_i` input, 32 bits: block-word load handshake, W0 first.
- `alu_op_o` output, `instruction_s`: operation for the ALU, driven with the package constants; non-pattern bits are 0.
- `alu_rd_o` output, 32 bits: ALU operand rd.
- `alu_rs_o` output, 32 bits: ALU operand rs.
- `alu_result_i` input, 32 bits: combinational ALU result, sampled at the end of each issue cycle.
- `out_valid_o` output, 1 bit / `out_ready_i` input, 1 bit / `out_data_o` output, 32 bits / `out_index_o` output, 6 bits: expanded word stream, where `out_index_o` is t.
- `busy_o` output, 1 bit: high in every state except IDLE.
- `done_o` output, 1 bit: one-cycle pulse after the last word has been accepted.

## Operation
- **States:** IDLE, LOAD, P1, P2, P3, P4, P5, EMIT, DONE.
- **IDLE:**
  - `start_i` moves to LOAD and clears the load counter.
  - All other inputs are ignored.
- **LOAD:**
  - Each `in_valid_i && in_ready_o` writes `in_data_i` into window slot `cnt[3:0]`.
  - After the 16th word, go to P1 with t=16.
- **Window:** 16×32 circular register file. Slot index is (t−k) mod 16, taken from the low 4 bits of the 6-bit t.
- **Per word t:**
  - P1 issues `kLB`, rs=W[t−2], rd=0; acc ← σ1.
  - P2 issues `kADDU`, rd=acc, rs=W[t−7]; acc ← sum.
  - P3 issues `kLA`, rs=W[t−15], rd=0; tmp ← σ0.
  - P4 issues `kADDU`, rd=acc, rs=tmp; acc ← sum.
  - P5 issues `kADDU`, rd=acc, rs=W[t−16]. The result is written to slot t mod 16 and to the output register; go to EMIT.
- **P5 slot reuse:** P5 reads and overwrites the same slot in the same cycle. The read value is the old word.
- **EMIT:**
  - `out_valid_o`=1, `out_data_o` and `out_index_o` stable until the handshake.
  - On `out_ready_i`: if t=ROUNDS−1 go to DONE, else t←t+1 and go to P1.
- **DONE:** `done_o`=1 for one cycle, then IDLE.
- **Idle ALU port:** outside P1..P5, `alu_op_o`, `alu_rd_o` and `alu_rs_o` are all 0.
- **Arithmetic:** all of it is done by the ALU, mod 2^32. The sequencer performs no arithmetic except counter increments.
- **Reset:** asynchronous reset from any state, including mid-word or mid-load, forces:
  - state IDLE;
  - counters 0 and window cleared;
  - every output 0 (`in_ready_o`, `out_valid_o`, `busy_o`, `done_o`, data, index, ALU ports).
- **Partial blocks:** a partially loaded block is discarded and never resumes.

## Timing
- **Load:** `in_ready_o` is registered-state decoded, so the 16 loads take at least 16 cycles.
- **Per-word latency:** 5 issue cycles, then `out_valid_o` rises in the cycle after P5.
  - With `out_ready_i` tied high, each word costs 6 cycles.
- **Total run:** from `start_i` to `done_o` is 1 + 16 + 6·(ROUNDS−16) + 1 cycles with no stalls. For ROUNDS=64 that is 306 cycles.
- **Backpressure:** EMIT holds indefinitely. No ALU operation is issued while in EMIT.
- **Ignored start:** `start_i` arriving while `busy_o`=1 is dropped.

## Configuration
- **`MSGSCHED_PASSTHRU_EN` defined:**
  - During LOAD each input word is also presented on the output port: `out_valid_o`=`in_valid_i`, `out_data_o`=`in_data_i`, `out_index_o`=cnt.
  - `in_ready_o` = `out_ready_i` in LOAD, so the handshake is a combinational pass-through.
  - Stream length becomes ROUNDS words, W0 onward.
- **Not defined:** `in_ready_o`=1 throughout LOAD; the output port is silent during LOAD; the stream starts at W16.

## Structure
- **Shared package `definitions`:**
  - reuse `instruction_s`, `kLA`, `kLB`, `kADDU`;
  - add the state enum `msg_sched_state_e`;
  - add the constant `kMsgWindow = 16`.
- **Sub-module `msg_window`:**
  - 16×32 register file;
  - four combinational read ports addressed t−2, t−7, t−15, t−16;
  - one write port;
  - asynchronous clear on `reset`.
- **Bench:** instantiates the real `alu` as the responder.

## Test plan
- **"abc" padded block:** W0=0x61626380, W1..W14=0, W15=0x00000018, `out_ready_i`=1 → W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6, with indices 16..19.
- **Full run, ROUNDS=64, no stalls:**
  - exactly 48 output beats, matching a software model;
  - `done_o` pulses once, 306 cycles after `start_i`.
- **Backpressure:** hold `out_ready_i`=0 for 10 cycles on word 20 → data and index stay constant, `alu_op_o`=0 throughout, and the next beat is index 21.
- **Reset mid-run:** assert `reset` during P3 of word 30 → next cycle all outputs are 0. A fresh start plus reload reproduces the golden W16.
- **`start_i` while busy:**
  - `start_i` pulsed during EMIT is ignored and the stream continues unchanged;
  - ROUNDS=17 yields exactly one beat (index 16), then `done_o`.
- **`MSGSCHED_PASSTHRU_EN` defined:** load 16 words with `out_ready_i` toggling → 64 beats with indices 0..63, the first 16 equal to the inputs, and no input lost.
